// File: rtl/uart_host_if_if.sv
// Bus and UART-side signal bundle for uart_host_if.
// master = CPU/UART-core side driver, slave = the host interface block.
interface uart_host_if_if;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;
    logic        irq;

    modport master (
        output addr, wr_en, rd_en, wdata, rx_data, rx_status, tx_status,
        input  rdata, tx_data, tx_en, irq
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata, rx_data, rx_status, tx_status,
        output rdata, tx_data, tx_en, irq
    );
endinterface

// File: rtl/uart_host_if.sv
// CPU bus <-> UART core bridge: TX/RX FIFOs, CON register, TX handshake FSM and level irq.
// Define UART_HOST_LOOPBACK_EN to route each TX byte straight into the RX FIFO.
module uart_host_if #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input logic           sysclk,
    input logic           rst,
    uart_host_if_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitIdle} tx_state_e;

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          irq_q, irq_d;
    logic          tx_irq_en_q, rx_irq_en_q, overrun_q, overrun_d;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW:0]   tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;

    logic          wr_txd, rd_rxd, wr_con;
    logic          tx_empty, tx_full, tx_push, tx_pop, tx_ready, tx_busy;
    logic          rx_empty, rx_full, rx_push, rx_pop, overrun_set;
    logic          rx_in_valid;
    logic [7:0]    rx_in_byte, tx_head, rx_head;
    logic [31:0]   con_rd;
    logic          unused_wdata;

    assign wr_txd = bus.wr_en && (bus.addr == 2'd0);
    assign rd_rxd = bus.rd_en && (bus.addr == 2'd1);
    assign wr_con = bus.wr_en && (bus.addr == 2'd2);

    // Full when pointers match in index but differ in the wrap bit.
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    assign tx_head = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign rx_head = rx_mem_q[rx_rptr_q[AW-1:0]];
    assign tx_push = wr_txd && !tx_full;

`ifdef UART_HOST_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx   = ^{bus.rx_data, bus.rx_status};
    assign tx_ready    = 1'b1;
    assign rx_in_valid = tx_pop;
    assign rx_in_byte  = tx_head;
`else
    assign tx_ready    = bus.tx_status;
    assign rx_in_valid = bus.rx_status;
    assign rx_in_byte  = bus.rx_data;
`endif

    // A pop on a full RX FIFO frees the slot the concurrent push lands in.
    assign rx_pop      = rd_rxd && !rx_empty;
    assign rx_push     = rx_in_valid && (!rx_full || rx_pop);
    assign overrun_set = rx_in_valid && rx_full && !rx_pop;

    assign tx_busy = (state_q != StIdle) || !tx_empty;
    assign con_rd  = {26'b0, tx_busy, overrun_q, !rx_empty, tx_full, rx_irq_en_q, tx_irq_en_q};
    assign unused_wdata = ^bus.wdata[31:8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_pop    = 1'b0;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (!tx_empty && tx_ready) begin
                    tx_pop = 1'b1;
`ifndef UART_HOST_LOOPBACK_EN
                    tx_en_d   = 1'b1;
                    tx_data_d = tx_head;
                    cnt_d     = '0;
                    state_d   = StWaitBusy;
`endif
                end
            end
            StWaitBusy: begin
                if (!bus.tx_status) begin
                    state_d = StWaitIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StWaitIdle: begin
                if (bus.tx_status) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (wr_con && bus.wdata[4]) begin
            overrun_d = 1'b0;
        end
        irq_d = (rx_irq_en_q && !rx_empty) ||
                (tx_irq_en_q && tx_empty && (state_q == StIdle));
    end

    always_comb begin
        bus.rdata = 32'b0;
        if (bus.rd_en) begin
            case (bus.addr)
                2'd1:    bus.rdata = rx_empty ? 32'b0 : {24'b0, rx_head};
                2'd2:    bus.rdata = con_rd;
                default: bus.rdata = 32'b0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            irq_q       <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
            if (wr_con) begin
                tx_irq_en_q <= bus.wdata[0];
                rx_irq_en_q <= bus.wdata[1];
            end
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.wdata[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_in_byte;
    end

    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign bus.irq     = irq_q;
endmodule
